// File: rtl/data_mem_arbiter.sv
// Arbitrates a single-port data memory between the CPU data port (m0) and the DMA/loader (m1).
// Registered round-robin grant with capped lock bursts; read data returned registered with a pulse.
module data_mem_arbiter #(
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 32,
   parameter  int MAX_BURST = 4,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_req,
   input  logic              m0_wen,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_wen,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              data_wen,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_write,
   input  logic [DATA_W-1:0] data_read,

   output logic [1:0]        dbg_state,
   output logic [CNT_W-1:0]  dbg_burst_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

   state_t             state;
   state_t             state_nxt;
   state_t             contend;
   logic               last;
   logic [CNT_W-1:0]   burst_cnt;
   logic               keep0;
   logic               keep1;
   logic               rd0;
   logic               rd1;

   // Handshake: a transfer happens in every cycle where req & gnt are both high; the requester
   // holds wen/addr/wdata stable from req rise through that cycle. gnt with req low is a wasted cycle.
   always_comb begin
      keep0 = m0_req && (!m1_req || (m0_lock && (burst_cnt < MAX_CNT)));
      keep1 = m1_req && (!m0_req || (m1_lock && (burst_cnt < MAX_CNT)));

      if (m0_req && m1_req) begin
         contend = last ? ST_OWN0 : ST_OWN1;
      end else if (m0_req) begin
         contend = ST_OWN0;
      end else if (m1_req) begin
         contend = ST_OWN1;
      end else begin
         contend = ST_IDLE;
      end

      state_nxt = contend;
      case (state)
         ST_OWN0: if (keep0) state_nxt = ST_OWN0;
         ST_OWN1: if (keep1) state_nxt = ST_OWN1;
         default: ;
      endcase
   end

   // last starts at 1 so m0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         last      <= 1'b1;
         burst_cnt <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
      end else begin
         state  <= state_nxt;
         m0_gnt <= (state_nxt == ST_OWN0);
         m1_gnt <= (state_nxt == ST_OWN1);
         if (state_nxt == ST_IDLE) begin
            burst_cnt <= '0;
         end else if (state_nxt == state) begin
            if (burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + 1'b1;
         end else begin
            burst_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            last      <= (state_nxt == ST_OWN1);
         end
      end
   end

   assign dbg_state     = state;
   assign dbg_burst_cnt = burst_cnt;

   // Memory side follows the registered owner; data_wen also needs the owner's live req.
   always_comb begin
      data_wen   = 1'b0;
      data_addr  = '0;
      data_write = '0;
      if (m0_gnt) begin
         data_wen   = m0_req && m0_wen;
         data_addr  = m0_addr;
         data_write = m0_wdata;
      end else if (m1_gnt) begin
         data_wen   = m1_req && m1_wen;
         data_addr  = m1_addr;
         data_write = m1_wdata;
      end
   end

   assign rd0 = m0_gnt && m0_req && !m0_wen;
   assign rd1 = m1_gnt && m1_req && !m1_wen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= rd0;
         m1_rvalid <= rd1;
         if (rd0) m0_rdata <= data_read;
         if (rd1) m1_rdata <= data_read;
      end
   end

endmodule
